// File: rtl/level_timeout_timer.sv
// Level-indexed timeout timer: counts qualified ticks to a per-level limit,
// pulses timeout on expiry, one-shot or auto-reload, saturating expiry count.
module level_timeout_timer #(
  parameter int CNT_W   = 8,
  parameter int LVL_W   = 3,
  parameter int NUM_LVL = 5,
  parameter logic [NUM_LVL*CNT_W-1:0] LIMITS =
    {8'd3, 8'd5, 8'd8, 8'd10, 8'd13},
  parameter int EXP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LVL_W-1:0] curLevel,
  input  logic             enable,
  input  logic             in,
  input  logic             start,
  input  logic             clear,
  input  logic             one_shot,
  output logic             timeout,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic [EXP_W-1:0] exp_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIM1 = LIMITS[CNT_W-1:0];

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [CNT_W-1:0] limit_q, limit_n;
  logic             mode_q, mode_n;
  logic             timeout_n;
  logic [EXP_W-1:0] exp_n;
  logic [CNT_W-1:0] lvl_limit;

  // Out-of-range levels (0 or above NUM_LVL) fall back to level 1.
  always_comb begin
    lvl_limit = LIM1;
    for (int k = 1; k < NUM_LVL; k++) begin
      if (curLevel == LVL_W'(k + 1))
        lvl_limit = LIMITS[k*CNT_W +: CNT_W];
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    limit_n   = limit_q;
    mode_n    = mode_q;
    timeout_n = 1'b0;
    exp_n     = exp_cnt;
    if (clear) begin
      state_n = IDLE;
      count_n = '0;
    end else if (start) begin
      state_n = RUN;
      count_n = '0;
      exp_n   = '0;
      limit_n = lvl_limit;
      mode_n  = one_shot;
    end else begin
      unique case (state)
        RUN: begin
          if (enable && in) begin
            if (count == limit_q) begin
              timeout_n = 1'b1;
              count_n   = '0;
              if (exp_cnt != '1)
                exp_n = exp_cnt + 1'b1;
              if (mode_q)
                state_n = DONE;
              else
                limit_n = lvl_limit;
            end else begin
              count_n = count + 1'b1;
            end
          end
        end
        IDLE:    count_n = '0;
        DONE:    count_n = '0;
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
  end

  // Status outputs are registered from next-state values so they
  // line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      limit_q   <= LIM1;
      mode_q    <= 1'b0;
      timeout   <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
      remaining <= LIM1;
      exp_cnt   <= '0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      limit_q   <= limit_n;
      mode_q    <= mode_n;
      timeout   <= timeout_n;
      running   <= (state_n == RUN);
      done      <= (state_n == DONE);
      remaining <= limit_n - count_n;
      exp_cnt   <= exp_n;
    end
  end

endmodule

// File: tb/tb_level_timeout_timer.sv
// Directed bench for level_timeout_timer: expiry timing, modes,
// level lookup, priorities, async reset and exp_cnt saturation.
module tb_level_timeout_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] curLevel;
  logic       enable, in, start, clear, one_shot;
  logic       timeout, running, done;
  logic [7:0] remaining;
  logic [3:0] exp_cnt;

  int vectors = 0;
  int miscompares = 0;

  level_timeout_timer dut (
    .clk(clk), .rst(rst), .curLevel(curLevel),
    .enable(enable), .in(in), .start(start),
    .clear(clear), .one_shot(one_shot),
    .timeout(timeout), .running(running), .done(done),
    .remaining(remaining), .exp_cnt(exp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] lvl, input logic os);
    curLevel = lvl;
    one_shot = os;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; curLevel = 3'd1; enable = 1'b0; in = 1'b0;
    start = 1'b0; clear = 1'b0; one_shot = 1'b0;
    #2;
    chk("rst_timeout", timeout, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_remaining", remaining, 13);
    chk("rst_exp", exp_cnt, 0);
    step();
    rst = 1'b0;
    step();
    chk("idle_running", running, 0);

    // Level 1 auto-reload; tick coincident with start is ignored
    enable = 1'b1; in = 1'b1;
    do_start(3'd1, 1'b0);
    chk("l1_start_running", running, 1);
    chk("l1_start_rem", remaining, 13);
    for (int p = 1; p <= 3; p++) begin
      for (int i = 1; i <= 13; i++) begin
        step();
        chk("l1_rem", remaining, 13 - i);
        chk("l1_no_to", timeout, 0);
      end
      step();
      chk("l1_to", timeout, 1);
      chk("l1_exp", exp_cnt, p);
      chk("l1_reload_rem", remaining, 13);
    end

    // Level 5 one-shot
    do_start(3'd5, 1'b1);
    chk("os_exp0", exp_cnt, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("os_rem", remaining, 3 - i);
    end
    step();
    chk("os_to", timeout, 1);
    chk("os_done", done, 1);
    chk("os_running", running, 0);
    chk("os_exp", exp_cnt, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("os_after_to", timeout, 0);
      chk("os_after_done", done, 1);
      chk("os_after_exp", exp_cnt, 1);
    end
    do_start(3'd5, 1'b1);
    chk("os_restart_run", running, 1);
    chk("os_restart_done", done, 0);
    chk("os_restart_exp", exp_cnt, 0);

    // Level change mid-period takes effect at reload
    do_start(3'd2, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) curLevel = 3'd4;
      step();
      chk("lc_rem", remaining, 10 - i);
      chk("lc_no_to", timeout, 0);
    end
    step();
    chk("lc_to1", timeout, 1);
    chk("lc_newlim", remaining, 5);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("lc_rem2", remaining, 5 - i);
      chk("lc_no_to2", timeout, 0);
    end
    step();
    chk("lc_to2", timeout, 1);

    // Enable pause and sparse ticks at level 5
    do_start(3'd5, 1'b0);
    step();
    chk("en_first", remaining, 2);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("en_hold", remaining, 2);
      chk("en_hold_to", timeout, 0);
    end
    enable = 1'b1;
    for (int c = 0; c < 9; c++) begin
      in = (c % 3 == 0);
      step();
      chk("sp_to", timeout, (c == 6) ? 1 : 0);
      chk("sp_rem", remaining, (c < 3) ? 1 : (c < 6) ? 0 : 3);
    end
    in = 1'b1;

    // start+clear together -> IDLE, exp held
    start = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; clear = 1'b0;
    chk("sc_running", running, 0);
    chk("sc_done", done, 0);
    chk("sc_exp", exp_cnt, 1);
    chk("sc_rem", remaining, 3);
    step();
    chk("sc_idle_stay", running, 0);

    // start on the expiry tick suppresses the pulse
    do_start(3'd5, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("se_pre", remaining, 0);
    do_start(3'd5, 1'b0);
    chk("se_no_to", timeout, 0);
    chk("se_rem", remaining, 3);
    chk("se_exp", exp_cnt, 0);

    // Out-of-range levels select level 1
    do_start(3'd0, 1'b0);
    chk("lvl0", remaining, 13);
    do_start(3'd7, 1'b0);
    chk("lvl7", remaining, 13);
    do_start(3'd3, 1'b0);
    chk("lvl3", remaining, 8);

    // Async reset mid-RUN
    for (int i = 0; i < 3; i++) step();
    chk("ar_pre", remaining, 5);
    #2 rst = 1'b1;
    #1;
    chk("ar_running", running, 0);
    chk("ar_rem", remaining, 13);
    chk("ar_exp", exp_cnt, 0);
    chk("ar_timeout", timeout, 0);
    #2 rst = 1'b0;
    step();
    chk("ar_idle", running, 0);
    chk("ar_idle_rem", remaining, 13);

    // Saturation: 20 expiries of a 4-tick period
    do_start(3'd5, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      for (int i = 0; i < 4; i++) step();
      if (e == 15) chk("sat15", exp_cnt, 15);
    end
    chk("sat20", exp_cnt, 15);
    chk("sat_to", timeout, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
